// File: rtl/ann_ctrl_pkg.sv
// Shared types and constants for the ANN search control path.
package ann_ctrl_pkg;

    localparam int unsigned CNT_WIDTH         = 16;
    localparam int unsigned K0_LATENCY_DEF    = 6;
    localparam int unsigned DRAIN_LATENCY_DEF = 5;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef enum logic [2:0] {
        StIdle,
        StExactFstRow,
        StExactFstRowWait,
        StSearchLeaf,
        StSearchWait,
        StProcessRow,
        StDone
    } state_e;

endpackage

// File: rtl/ctrl_counter.sv
// 16-bit loadable up-counter with synchronous clear and terminal-value compare.
module ctrl_counter
    import ann_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic load_i,
    input  cnt_t load_val_i,
    input  logic en_i,
    input  cnt_t term_val_i,
    output cnt_t cnt_o,
    output logic term_o
);

    cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/main_search_sequencer.sv
// Sequences the exact first-row sweep, then per-query tree search and leaf processing.
module main_search_sequencer
    import ann_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LEAVES    = 64,
    parameter int unsigned NUM_QUERIES   = 16,
    parameter int unsigned K0_LATENCY    = K0_LATENCY_DEF,
    parameter int unsigned DRAIN_LATENCY = DRAIN_LATENCY_DEF,
    parameter int unsigned ADDR_WIDTH    = $clog2(NUM_LEAVES),
    parameter int unsigned QIDX_WIDTH    = (NUM_QUERIES > 1) ? $clog2(NUM_QUERIES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fsm_start,
    input  logic                  fsm_abort,
    output logic                  leaf_mem_ren,
    output logic [ADDR_WIDTH-1:0] leaf_mem_radr,
    output logic                  k0_query_valid,
    output logic                  rm_restart,
    output logic                  s0_valid_in,
    input  logic                  s0_valid_out,
    input  logic [ADDR_WIDTH-1:0] s0_leaf_idx,
    output logic [QIDX_WIDTH-1:0] query_idx,
    output logic                  busy,
    output logic                  fsm_done
);

    state_e                state_q, state_d;
    logic [QIDX_WIDTH-1:0] qidx_q, qidx_d;
    logic [ADDR_WIDTH-1:0] leaf_idx_q, leaf_idx_d;
    cnt_t                  cnt, term_val;
    logic                  cnt_term, cnt_en, last_query;

    assign last_query = (qidx_q == QIDX_WIDTH'(NUM_QUERIES - 1));
    assign cnt_en     = (state_q == StExactFstRow) || (state_q == StExactFstRowWait) ||
                        (state_q == StProcessRow);

    always_comb begin
        term_val = '0;
        unique case (state_q)
            StExactFstRow:     term_val = cnt_t'(NUM_LEAVES);
            StExactFstRowWait: term_val = cnt_t'(DRAIN_LATENCY);
            StProcessRow:      term_val = cnt_t'(K0_LATENCY + DRAIN_LATENCY);
            default:           term_val = '0;
        endcase
    end

    // Counter restarts from zero on every state change, including abort.
    ctrl_counter u_ctrl_counter (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clr_i      (state_d != state_q),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (cnt_en),
        .term_val_i (term_val),
        .cnt_o      (cnt),
        .term_o     (cnt_term)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            qidx_q     <= '0;
            leaf_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            qidx_q     <= qidx_d;
            leaf_idx_q <= leaf_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        qidx_d     = qidx_q;
        leaf_idx_d = leaf_idx_q;
        unique case (state_q)
            StIdle: begin
                if (fsm_start) begin
                    state_d = StExactFstRow;
                    qidx_d  = '0;
                end
            end
            StExactFstRow: begin
                if (cnt_term) state_d = StExactFstRowWait;
            end
            StExactFstRowWait: begin
                if (cnt_term) begin
                    if (NUM_QUERIES == 1) begin
                        state_d = StDone;
                    end else begin
                        qidx_d  = qidx_q + QIDX_WIDTH'(1);
                        state_d = StSearchLeaf;
                    end
                end
            end
            StSearchLeaf: state_d = StSearchWait;
            StSearchWait: begin
                if (s0_valid_out) begin
                    leaf_idx_d = s0_leaf_idx;
                    state_d    = StProcessRow;
                end
            end
            StProcessRow: begin
                if (cnt_term) begin
                    if (last_query) begin
                        state_d = StDone;
                    end else begin
                        qidx_d  = qidx_q + QIDX_WIDTH'(1);
                        state_d = StSearchLeaf;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (fsm_abort && (state_q != StIdle)) begin
            state_d = StIdle;
            qidx_d  = '0;
        end
    end

    always_comb begin
        leaf_mem_ren   = 1'b0;
        leaf_mem_radr  = '0;
        k0_query_valid = 1'b0;
        rm_restart     = 1'b0;
        s0_valid_in    = 1'b0;
        fsm_done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fsm_start) leaf_mem_ren = 1'b1;
            end
            StExactFstRow: begin
                k0_query_valid = 1'b1;
                if (cnt < cnt_t'(NUM_LEAVES - 1)) begin
                    leaf_mem_ren  = 1'b1;
                    leaf_mem_radr = ADDR_WIDTH'(cnt + cnt_t'(1));
                end
                rm_restart = (cnt == cnt_t'(K0_LATENCY)) && !fsm_abort;
            end
            StSearchLeaf: s0_valid_in = !fsm_abort;
            StProcessRow: begin
                if (cnt == '0) begin
                    leaf_mem_ren   = 1'b1;
                    leaf_mem_radr  = leaf_idx_q;
                    k0_query_valid = 1'b1;
                end
                rm_restart = (cnt == cnt_t'(K0_LATENCY)) && !fsm_abort;
            end
            StDone:  fsm_done = !fsm_abort;
            default: ;
        endcase
    end

    assign query_idx = qidx_q;
    assign busy      = (state_q != StIdle);

endmodule
